// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers and accumulator state type for the pipelined adder tree.
package adder_tree_pkg;

    typedef enum logic {IDLE, ACCUM} acc_state_t;

    function automatic int f_levels(input int size);
        return (size <= 1) ? 1 : $clog2(size);
    endfunction

    function automatic int f_nodes(input int size, input int level);
        return (size + (1 << level) - 1) >> level;
    endfunction

    function automatic int f_sum_width(input int size, input int dw);
        return dw + $clog2(size);
    endfunction

endpackage

// File: rtl/pipelined_adder_tree_if.sv
// Beat-in / result-out handshake bundle for the pipelined adder tree.
interface pipelined_adder_tree_if
    import adder_tree_pkg::*;
#(
    parameter int SIZE       = 5,
    parameter int DATA_WIDTH = 4,
    parameter int ACCUMULATE = 0,
    parameter int ACC_WIDTH  = 16
) ();

    localparam int OUT_WIDTH = (ACCUMULATE != 0) ? ACC_WIDTH : f_sum_width(SIZE, DATA_WIDTH);

    logic                       in_valid;
    logic                       in_ready;
    logic                       in_last;
    logic [SIZE*DATA_WIDTH-1:0] inputs;
    logic                       out_valid;
    logic                       out_ready;
    logic [OUT_WIDTH-1:0]       out_data;
    logic                       out_overflow;

    modport master (
        output in_valid, in_last, inputs, out_ready,
        input  in_ready, out_valid, out_data, out_overflow
    );

    modport slave (
        input  in_valid, in_last, inputs, out_ready,
        output in_ready, out_valid, out_data, out_overflow
    );

endinterface

// File: rtl/adder_tree_level.sv
// One registered pairwise-add level; an odd trailing node passes through widened by one bit.
module adder_tree_level #(
    parameter int N_IN = 2,
    parameter int W_IN = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  in_valid,
    input  logic [N_IN*W_IN-1:0]                  in_data,
    output logic                                  out_valid,
    output logic [((N_IN + 1) / 2)*(W_IN + 1)-1:0] out_data
);

    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*(W_IN+1)-1:0] sums;

    for (genvar j = 0; j < N_OUT; j++) begin : g_node
        if (2 * j + 1 < N_IN) begin : g_pair
            assign sums[j*(W_IN+1) +: W_IN+1] = {1'b0, in_data[2*j*W_IN +: W_IN]}
                                              + {1'b0, in_data[(2*j+1)*W_IN +: W_IN]};
        end else begin : g_pass
            assign sums[j*(W_IN+1) +: W_IN+1] = {1'b0, in_data[2*j*W_IN +: W_IN]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= sums;
        end
    end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Full-precision pipelined sum of SIZE operands with global backpressure and
// optional per-packet accumulation of successive beats.
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int SIZE       = 5,
    parameter int DATA_WIDTH = 4,
    parameter int ACCUMULATE = 0,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pipelined_adder_tree_if.slave   bus
);

    localparam int LEVELS     = f_levels(SIZE);
    localparam int SUM_WIDTH  = f_sum_width(SIZE, DATA_WIDTH);
    localparam int TREE_WIDTH = DATA_WIDTH + LEVELS;

    logic                  advance;
    logic                  tree_valid;
    logic [TREE_WIDTH-1:0] tree_full;
    logic [SUM_WIDTH-1:0]  tree_sum;

    // Every stage moves together; a stalled result freezes the whole pipe.
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int N_IN  = f_nodes(SIZE, k);
        localparam int W_IN  = DATA_WIDTH + k;
        localparam int N_OUT = f_nodes(SIZE, k + 1);

        logic                      lvl_in_valid;
        logic [N_IN*W_IN-1:0]      lvl_in;
        logic                      lvl_out_valid;
        logic [N_OUT*(W_IN+1)-1:0] lvl_out;

        if (k == 0) begin : g_src
            assign lvl_in_valid = bus.in_valid;
            assign lvl_in       = bus.inputs;
        end else begin : g_chain
            assign lvl_in_valid = g_lvl[k-1].lvl_out_valid;
            assign lvl_in       = g_lvl[k-1].lvl_out;
        end

        adder_tree_level #(.N_IN(N_IN), .W_IN(W_IN)) u_level (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (lvl_in_valid),
            .in_data   (lvl_in),
            .out_valid (lvl_out_valid),
            .out_data  (lvl_out)
        );
    end

    assign tree_valid = g_lvl[LEVELS-1].lvl_out_valid;
    assign tree_full  = g_lvl[LEVELS-1].lvl_out;
    assign tree_sum   = tree_full[SUM_WIDTH-1:0];

    if (ACCUMULATE == 0) begin : g_direct
        assign bus.out_valid    = tree_valid;
        assign bus.out_data     = tree_sum;
        assign bus.out_overflow = 1'b0;
    end else begin : g_accum
        acc_state_t           state, state_next;
        logic [ACC_WIDTH-1:0] acc, acc_next, beat, emit_data, out_data_r;
        logic [ACC_WIDTH:0]   acc_sum;
        logic                 ovf, ovf_next, emit, emit_ovf, out_valid_r, out_ovf_r;
        logic [LEVELS-1:0]    last_pipe;
        logic                 tree_last;

        // The last flag rides alongside the tree so it lines up with its beat's sum.
        always_ff @(posedge clk) begin
            if (rst) begin
                last_pipe <= '0;
            end else if (advance) begin
                last_pipe[0] <= bus.in_last;
                for (int i = 1; i < LEVELS; i++) last_pipe[i] <= last_pipe[i-1];
            end
        end

        assign tree_last = last_pipe[LEVELS-1];
        assign beat      = ACC_WIDTH'(tree_sum);
        assign acc_sum   = {1'b0, acc} + {1'b0, beat};

        always_comb begin
            state_next = state;
            acc_next   = acc;
            ovf_next   = ovf;
            emit       = 1'b0;
            emit_data  = '0;
            emit_ovf   = 1'b0;
            if (tree_valid) begin
                case (state)
                    IDLE: begin
                        if (tree_last) begin
                            emit      = 1'b1;
                            emit_data = beat;
                        end else begin
                            acc_next   = beat;
                            ovf_next   = 1'b0;
                            state_next = ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (tree_last) begin
                            emit       = 1'b1;
                            emit_data  = acc_sum[ACC_WIDTH-1:0];
                            emit_ovf   = ovf || acc_sum[ACC_WIDTH];
                            acc_next   = '0;
                            ovf_next   = 1'b0;
                            state_next = IDLE;
                        end else begin
                            acc_next = acc_sum[ACC_WIDTH-1:0];
                            ovf_next = ovf || acc_sum[ACC_WIDTH];
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        // A result register that is not being refilled drops valid once consumed.
        always_ff @(posedge clk) begin
            if (rst) begin
                state       <= IDLE;
                acc         <= '0;
                ovf         <= 1'b0;
                out_valid_r <= 1'b0;
                out_data_r  <= '0;
                out_ovf_r   <= 1'b0;
            end else if (advance) begin
                state       <= state_next;
                acc         <= acc_next;
                ovf         <= ovf_next;
                out_valid_r <= emit;
                if (emit) begin
                    out_data_r <= emit_data;
                    out_ovf_r  <= emit_ovf;
                end
            end
        end

        assign bus.out_valid    = out_valid_r;
        assign bus.out_data     = out_data_r;
        assign bus.out_overflow = out_ovf_r;
    end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed checks of the adder tree in direct, accumulate, single-operand and power-of-two builds.
module tb_pipelined_adder_tree;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipelined_adder_tree_if #(.SIZE(5), .DATA_WIDTH(4), .ACCUMULATE(0), .ACC_WIDTH(16)) if0 ();
    pipelined_adder_tree_if #(.SIZE(5), .DATA_WIDTH(5), .ACCUMULATE(1), .ACC_WIDTH(8))  if1 ();
    pipelined_adder_tree_if #(.SIZE(1), .DATA_WIDTH(4), .ACCUMULATE(0), .ACC_WIDTH(16)) if2 ();
    pipelined_adder_tree_if #(.SIZE(8), .DATA_WIDTH(4), .ACCUMULATE(0), .ACC_WIDTH(16)) if3 ();

    pipelined_adder_tree #(.SIZE(5), .DATA_WIDTH(4), .ACCUMULATE(0), .ACC_WIDTH(16)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    pipelined_adder_tree #(.SIZE(5), .DATA_WIDTH(5), .ACCUMULATE(1), .ACC_WIDTH(8))  u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    pipelined_adder_tree #(.SIZE(1), .DATA_WIDTH(4), .ACCUMULATE(0), .ACC_WIDTH(16)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    pipelined_adder_tree #(.SIZE(8), .DATA_WIDTH(4), .ACCUMULATE(0), .ACC_WIDTH(16)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    function automatic logic [19:0] pack_w4(input logic [3:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [24:0] pack_w5(input logic [4:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (if0.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid0 got=%b exp=0", if0.out_valid); end
        total++; if (if0.out_data !== 7'd0) begin bad++; $display("[TB] FAIL reset_data0 got=%0d exp=0", if0.out_data); end
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid1 got=%b exp=0", if1.out_valid); end
        total++; if (if1.out_data !== 8'd0) begin bad++; $display("[TB] FAIL reset_data1 got=%0d exp=0", if1.out_data); end
        total++; if (if1.out_overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf1 got=%b exp=0", if1.out_overflow); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (if0.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready0 got=%b exp=1", if0.in_ready); end
        total++; if (if1.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready1 got=%b exp=1", if1.in_ready); end
    endtask

    task automatic test_single();
        if0.out_ready = 1'b1;
        if0.inputs    = pack_w4(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        if0.in_valid  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) if0.in_valid = 1'b0;
            total++;
            if (if0.out_valid !== (c == 3)) begin
                bad++; $display("[TB] FAIL single_valid c=%0d got=%b exp=%b", c, if0.out_valid, (c == 3));
            end
            if (c == 3) begin
                total++;
                if (if0.out_data !== 7'd15) begin bad++; $display("[TB] FAIL single_data got=%0d exp=15", if0.out_data); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_res = 0;
        if0.out_ready = 1'b1;
        if0.inputs    = {5{4'hF}};
        if0.in_valid  = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 20) if0.in_valid = 1'b0;
            total++;
            if (if0.out_valid !== (c >= 3 && c <= 22)) begin
                bad++; $display("[TB] FAIL b2b_valid c=%0d got=%b exp=%b", c, if0.out_valid, (c >= 3 && c <= 22));
            end
            if (if0.out_valid === 1'b1) begin
                n_res++;
                total++;
                if (if0.out_data !== 7'd75) begin bad++; $display("[TB] FAIL b2b_data c=%0d got=%0d exp=75", c, if0.out_data); end
            end
        end
        total++;
        if (n_res != 20) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=20", n_res); end
    endtask

    task automatic test_random_stall();
        logic [6:0] exp_q[$];
        logic [6:0] want, hold_data, cur_sum;
        logic [3:0] ops[5];
        logic       prev_stall = 1'b0, took = 1'b0;
        int         n_in = 0, n_out = 0;
        if0.in_valid = 1'b0;
        cur_sum      = '0;
        hold_data    = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                total++;
                if (if0.out_valid !== 1'b1 || if0.out_data !== hold_data) begin
                    bad++; $display("[TB] FAIL stall_hold c=%0d got=%b/%0d exp=1/%0d", c, if0.out_valid, if0.out_data, hold_data);
                end
            end
            if (!if0.in_valid || took) begin
                if (c < 260 && $urandom_range(0, 3) != 0) begin
                    cur_sum = '0;
                    for (int i = 0; i < 5; i++) begin
                        ops[i]  = 4'($urandom_range(0, 15));
                        cur_sum = cur_sum + 7'(ops[i]);
                    end
                    if0.inputs   = pack_w4(ops[0], ops[1], ops[2], ops[3], ops[4]);
                    if0.in_valid = 1'b1;
                end else begin
                    if0.in_valid = 1'b0;
                end
            end
            if0.out_ready = (c >= 260) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            took = if0.in_valid && if0.in_ready;
            if (took) begin
                exp_q.push_back(cur_sum);
                n_in++;
            end
            if (if0.out_valid && if0.out_ready) begin
                n_out++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("[TB] FAIL rand_extra c=%0d got=%0d exp=none", c, if0.out_data);
                end else begin
                    want = exp_q.pop_front();
                    if (if0.out_data !== want) begin bad++; $display("[TB] FAIL rand_data c=%0d got=%0d exp=%0d", c, if0.out_data, want); end
                end
            end
            prev_stall = if0.out_valid && !if0.out_ready;
            hold_data  = if0.out_data;
        end
        if0.in_valid = 1'b0;
        total++;
        if (exp_q.size() != 0 || n_in != n_out) begin
            bad++; $display("[TB] FAIL rand_count got=%0d exp=%0d", n_out, n_in);
        end
    endtask

    task automatic test_accumulate();
        if1.out_ready = 1'b1;
        if1.inputs    = {5{5'd20}};
        if1.in_last   = 1'b0;
        if1.in_valid  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2) if1.in_last = 1'b1;
            if (c == 3) if1.inputs = pack_w5(5'd1, 5'd1, 5'd1, 5'd2, 5'd2);
            if (c == 4) begin if1.in_valid = 1'b0; if1.in_last = 1'b0; end
            total++;
            if (if1.out_valid !== (c == 6 || c == 7)) begin
                bad++; $display("[TB] FAIL acc_valid c=%0d got=%b exp=%b", c, if1.out_valid, (c == 6 || c == 7));
            end
            if (c == 6) begin
                total++;
                if (if1.out_data !== 8'd44 || if1.out_overflow !== 1'b1) begin
                    bad++; $display("[TB] FAIL acc_wrap got=%0d/%b exp=44/1", if1.out_data, if1.out_overflow);
                end
            end
            if (c == 7) begin
                total++;
                if (if1.out_data !== 8'd7 || if1.out_overflow !== 1'b0) begin
                    bad++; $display("[TB] FAIL acc_single got=%0d/%b exp=7/0", if1.out_data, if1.out_overflow);
                end
            end
        end
    endtask

    task automatic test_sizes();
        if2.out_ready = 1'b1;
        if3.out_ready = 1'b1;
        if2.inputs    = 4'd9;
        if3.inputs    = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        if2.in_valid  = 1'b1;
        if3.in_valid  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++;
            if (if2.out_valid !== (c == 1 || c == 2)) begin
                bad++; $display("[TB] FAIL s1_valid c=%0d got=%b exp=%b", c, if2.out_valid, (c == 1 || c == 2));
            end
            total++;
            if (if3.out_valid !== (c == 3 || c == 4)) begin
                bad++; $display("[TB] FAIL s8_valid c=%0d got=%b exp=%b", c, if3.out_valid, (c == 3 || c == 4));
            end
            if (c == 1) begin
                total++; if (if2.out_data !== 4'd9) begin bad++; $display("[TB] FAIL s1_data0 got=%0d exp=9", if2.out_data); end
                if2.inputs = 4'd15;
                if3.inputs = {8{4'hF}};
            end
            if (c == 2) begin
                total++; if (if2.out_data !== 4'd15) begin bad++; $display("[TB] FAIL s1_data1 got=%0d exp=15", if2.out_data); end
                if2.in_valid = 1'b0;
                if3.in_valid = 1'b0;
            end
            if (c == 3) begin
                total++; if (if3.out_data !== 7'd36) begin bad++; $display("[TB] FAIL s8_data0 got=%0d exp=36", if3.out_data); end
            end
            if (c == 4) begin
                total++; if (if3.out_data !== 7'd120) begin bad++; $display("[TB] FAIL s8_data1 got=%0d exp=120", if3.out_data); end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        if1.out_ready = 1'b1;
        if1.inputs    = pack_w5(5'd1, 5'd1, 5'd1, 5'd2, 5'd2);
        if1.in_last   = 1'b1;
        if1.in_valid  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            case (c)
                1: begin if1.inputs = {5{5'd20}}; if1.in_last = 1'b0; end
                2: if1.inputs = {5{5'd10}};
                3: begin if1.in_valid = 1'b0; if1.out_ready = 1'b0; end
                4: begin
                    total++;
                    if (if1.out_valid !== 1'b1 || if1.out_data !== 8'd7 || if1.in_ready !== 1'b0) begin
                        bad++; $display("[TB] FAIL rstmid_stall got=%b/%0d/%b exp=1/7/0", if1.out_valid, if1.out_data, if1.in_ready);
                    end
                    rst = 1'b1;
                end
                5: begin
                    total++;
                    if (if1.out_valid !== 1'b0 || if1.out_data !== 8'd0 || if1.out_overflow !== 1'b0) begin
                        bad++; $display("[TB] FAIL rstmid_clear got=%b/%0d/%b exp=0/0/0", if1.out_valid, if1.out_data, if1.out_overflow);
                    end
                    rst           = 1'b0;
                    if1.out_ready = 1'b1;
                    #1;
                    total++;
                    if (if1.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_ready got=%b exp=1", if1.in_ready); end
                    if1.inputs   = {5{5'd2}};
                    if1.in_last  = 1'b0;
                    if1.in_valid = 1'b1;
                end
                6: begin if1.inputs = {5{5'd4}}; if1.in_last = 1'b1; end
                7: begin if1.in_valid = 1'b0; if1.in_last = 1'b0; end
                default: ;
            endcase
            if (c >= 6) begin
                total++;
                if (if1.out_valid !== (c == 10)) begin
                    bad++; $display("[TB] FAIL rstmid_valid c=%0d got=%b exp=%b", c, if1.out_valid, (c == 10));
                end
                if (c == 10) begin
                    total++;
                    if (if1.out_data !== 8'd30 || if1.out_overflow !== 1'b0) begin
                        bad++; $display("[TB] FAIL rstmid_sum got=%0d/%b exp=30/0", if1.out_data, if1.out_overflow);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if0.in_valid = 1'b0; if0.in_last = 1'b0; if0.inputs = '0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_last = 1'b0; if1.inputs = '0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.in_last = 1'b0; if2.inputs = '0; if2.out_ready = 1'b1;
        if3.in_valid = 1'b0; if3.in_last = 1'b0; if3.inputs = '0; if3.out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_random_stall();
        test_accumulate();
        test_sizes();
        test_reset_mid_packet();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
